// File: rtl/sound_ram_reader_if.sv
// ============================================================================
// Module      : sound_ram_reader_if
// Description : Read-client port between the sound-RAM reader and SDRAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sound_ram_reader_if;
    logic        rd;      // one-cycle read request
    logic [20:0] addr;    // 32-bit-word address
    logic [31:0] q;       // read data
    logic        ready;   // data-valid pulse

    modport master (output rd, output addr, input q, input ready);
    modport slave  (input rd, input addr, output q, output ready);
endinterface

`default_nettype wire

// File: rtl/sound_ram_reader.sv
// ============================================================================
// Module      : sound_ram_reader
// Description : Services $C03D sound-RAM reads from SDRAM and tracks the
//               GLU sound pointer. Macro SOUND_RAM_READER_PREFETCH_EN selects
//               prefetch-on-pointer-load instead of IIgs one-read lag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sound_ram_reader #(
    parameter logic ENABLE = 1'b1
) (
    input  wire logic        clk_logic,
    input  wire logic        system_reset_n,
    input  wire logic        ptr_wr_i,
    input  wire logic [15:0] ptr_i,
    input  wire logic        ram_mode_i,
    input  wire logic        auto_inc_i,
    input  wire logic        data_rd_i,
    output logic      [7:0]  rd_data_o,
    output logic             ptr_inc_o,
    output logic             busy_o,
    output logic             overrun_o,
    sound_ram_reader_if.master mem
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q;
    logic [15:0] fetch_addr_q, fetch_addr_d;
    logic [15:0] pend_addr_q, pend_addr_d;
    logic        pend_q, pend_d;
    logic        stale_q, stale_d;
    logic [7:0]  rd_data_q;
    logic        ptr_inc_q;
    logic        busy_q;
    logic        overrun_q;
    logic        mem_rd_q;

    logic        w_load;
    logic        w_accept;
    logic [15:0] w_addr_base;
    logic [15:0] w_addr_next;
    logic        w_fetch_req;
    logic [15:0] w_fetch_addr;
    logic        w_supersede;
    logic        w_done;
    logic        w_free;
    logic        w_launch;
    logic [15:0] w_launch_addr;
    logic        w_drop;
    logic        w_capture;

    always_comb begin
        w_load      = ENABLE && ptr_wr_i;
        w_accept    = ENABLE && data_rd_i && ram_mode_i;
        // A same-cycle pointer load takes effect before the read uses it
        w_addr_base = w_load ? ptr_i : addr_q;
        w_addr_next = (w_accept && auto_inc_i) ? (w_addr_base + 16'd1) : w_addr_base;
`ifdef SOUND_RAM_READER_PREFETCH_EN
        w_fetch_req  = w_load || w_accept;
        w_fetch_addr = w_addr_next;
        w_supersede  = w_load;
`else
        w_fetch_req  = w_accept;
        w_fetch_addr = w_addr_base;
        w_supersede  = 1'b0;
`endif
        w_done = (state_q == ST_WAIT) && mem.ready;
        w_free = (state_q == ST_IDLE) || w_done;

        w_launch      = 1'b0;
        w_launch_addr = w_fetch_addr;
        pend_d        = pend_q;
        pend_addr_d   = pend_addr_q;
        w_drop        = 1'b0;

        if (w_free) begin
            if (pend_q && !w_supersede) begin
                w_launch      = 1'b1;
                w_launch_addr = pend_addr_q;
                pend_d        = w_fetch_req;
                pend_addr_d   = w_fetch_addr;
            end else begin
                w_launch      = w_fetch_req;
                w_launch_addr = w_fetch_addr;
                pend_d        = 1'b0;
            end
        end else if (w_fetch_req) begin
            // A pointer load replaces any queued fetch; a read never does
            if (!pend_q || w_supersede) begin
                pend_d      = 1'b1;
                pend_addr_d = w_fetch_addr;
            end else begin
                w_drop = 1'b1;
            end
        end

        if (w_done || (state_q == ST_IDLE)) begin
            stale_d = 1'b0;
        end else begin
            stale_d = stale_q || w_supersede;
        end
        w_capture = w_done && !stale_q && !w_supersede;

        fetch_addr_d = w_launch ? w_launch_addr : fetch_addr_q;

        if (w_launch) begin
            state_d = ST_REQ;
        end else if (state_q == ST_REQ) begin
            state_d = ST_WAIT;
        end else if (w_done) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_q;
        end
    end

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= 16'h0000;
            fetch_addr_q <= 16'h0000;
            pend_addr_q  <= 16'h0000;
            pend_q       <= 1'b0;
            stale_q      <= 1'b0;
            rd_data_q    <= 8'h00;
            ptr_inc_q    <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            mem_rd_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= w_addr_next;
            fetch_addr_q <= fetch_addr_d;
            pend_addr_q  <= pend_addr_d;
            pend_q       <= pend_d;
            stale_q      <= stale_d;
            ptr_inc_q    <= w_accept && auto_inc_i;
            busy_q       <= (state_d != ST_IDLE);
            mem_rd_q     <= w_launch;
            if (w_capture) begin
                rd_data_q <= mem.q[8*fetch_addr_q[1:0] +: 8];
            end
            if (w_drop) begin
                overrun_q <= 1'b1;
            end else if (w_load) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign rd_data_o = rd_data_q;
    assign ptr_inc_o = ptr_inc_q;
    assign busy_o    = busy_q;
    assign overrun_o = overrun_q;
    assign mem.rd    = mem_rd_q;
    assign mem.addr  = {4'b0000, 1'b1, 2'b00, fetch_addr_q[15:2]};

endmodule

`default_nettype wire

// File: doc/sound_ram_reader.md
# sound_ram_reader

Read-side companion to the GLU sound-RAM write path. It services CPU reads of the Sound Data register ($C03D) in RAM mode by fetching bytes from the 64 KB sound-RAM window in SDRAM through a dedicated client port. It holds the result for the bus and keeps an internal copy of the sound pointer, including auto-increment. It sits beside the GLU register file, is fed qualified strobes from it, and owns one `sdram_port_if`-style read client.

## Interface
Parameters:
- ENABLE, 1'b1, when 0 no memory requests are ever issued and all outputs hold their reset values.

Ports:
- clk_logic  in  1  system logic clock; the only clock.
- system_reset_n  in  1  reset, asynchronous and active-low.
- ptr_wr_i  in  1  one-cycle pulse: GLU pointer register written.
- ptr_i  in  16  pointer value `{hi,lo}` to load on ptr_wr_i.
- ram_mode_i  in  1  Sound Control bit 6; reads are serviced only when 1.
- auto_inc_i  in  1  Sound Control bit 5.
- data_rd_i  in  1  one-cycle pulse: CPU read of $C03D, already qualified by phi0/strobe.
- rd_data_o  out  8  byte presented to the bus for $C03D reads.
- ptr_inc_o  out  1  one-cycle pulse telling the GLU to increment its pointer.
- busy_o  out  1  fetch in flight or pending.
- overrun_o  out  1  sticky: a read request was dropped.
- mem_rd_o  out  1  SDRAM read request pulse.
- mem_addr_o  out  21  `{4'b0,1'b1,2'b0,addr_r[15:2]}`, the 32-bit-word address.
- mem_q_i  in  32  SDRAM read data.
- mem_ready_i  in  1  SDRAM data-valid pulse.

## Operation
- addr_r (16 b) is loaded from ptr_i on ptr_wr_i.
- On data_rd_i with ram_mode_i=1, a read is accepted. If ram_mode_i=0, data_rd_i is ignored entirely.
- Accepted read:
  - rd_data_o is not changed by the acceptance itself; it already holds the last fetched byte.
  - A fetch is scheduled.
  - If auto_inc_i=1, addr_r increments (16-bit wrap, FFFF→0000) and ptr_inc_o pulses in the same cycle.
- Fetch address without the macro: the pre-increment addr_r. This gives IIgs one-read lag: the first read after a pointer load returns stale data.
- FSM states:
  - IDLE: a scheduled fetch moves to REQ.
  - REQ: mem_rd_o=1 for exactly one cycle, fetch_addr latched → WAIT.
  - WAIT: on mem_ready_i, capture `mem_q_i[8*fetch_addr[1:0] +: 8]` → IDLE, or → REQ if a fetch is pending.
- Pending slot is one deep. An accepted read while busy with the slot already full is dropped (no fetch), sets overrun_o, and still performs the auto-increment and the ptr_inc_o pulse.
- overrun_o clears on ptr_wr_i.
- ptr_wr_i together with data_rd_i in the same cycle: the load wins, and the read uses the new pointer.
- ptr_wr_i during WAIT: the in-flight fetch completes and its data is captured normally (IIgs semantics). The prefetch variant differs; see Configuration.

## Timing
- Reset values: rd_data_o=00, ptr_inc_o=0, busy_o=0, overrun_o=0, mem_rd_o=0, mem_addr_o={4'b0,1'b1,16'b0}, addr_r=0000, FSM=IDLE, pending=0. Reset applies asynchronously; any in-flight fetch is abandoned, and a later mem_ready_i is ignored while in IDLE.
- data_rd_i at cycle N → REQ at N+1 (mem_rd_o high N+1) → WAIT from N+2.
- mem_ready_i at cycle M → rd_data_o valid at M+1, busy_o low at M+1 if nothing is pending.
- mem_addr_o is stable from REQ through the ready cycle.
- ptr_inc_o is registered: it is high in cycle N+1 for a read in cycle N.
- mem_ready_i outside WAIT is ignored.

## Configuration
- SOUND_RAM_READER_PREFETCH_EN defined:
  - ptr_wr_i schedules a fetch of the new addr_r.
  - Accepted reads fetch the post-increment addr_r.
  - rd_data_o therefore always reflects the current pointer after the fetch completes (no dummy read).
  - ptr_wr_i during WAIT marks the in-flight data stale: it is discarded, and the new address is fetched next.
- Not defined: IIgs-accurate lag behaviour as in Operation. Pointer loads never fetch.

## Test plan
- Reset → all outputs at reset values. Load ptr 1234 → no mem_rd_o without the macro; one mem_rd_o with mem_addr_o word 048D with the macro.
- Non-prefetch: RAM[1234]=A5, RAM[1235]=5A, auto_inc=1, load 1234, three reads → rd_data_o after each completes: A5, 5A, RAM[1236]. Bus values seen at each read: 00, A5, 5A. ptr_inc_o pulses 3 times.
- Byte lanes: loads to 2000..2003 with mem_q_i=DDCCBBAA → bytes AA, BB, CC, DD respectively.
- Wrap: auto_inc=1, load FFFF, read → addr_r=0000; next fetch word address 0000.
- Busy: mem_ready_i delayed 20 cycles, three reads back-to-back → two fetches issued, overrun_o=1, three ptr_inc_o pulses; ptr_wr_i clears overrun_o.
- ram_mode_i=0: reads → no mem_rd_o, no ptr_inc_o. Asserting system_reset_n low mid-WAIT → IDLE immediately, and a late mem_ready_i leaves rd_data_o=00.
